// File: rtl/rw_flow_ctrl_burst.sv
// rw_flow_ctrl_burst: sequences memory write, burst memory readout and calc-result transmit
// Ports: clk, reset (async active-low); valid_cmd/rw/active/mode/addr_in/burst_len from the command decoder;
//        tx_done from the serial transmitter; ac_mem/rw_mem/mem_addr drive memory; p_load/tx_dat drive TX;
//        busy while an operation runs; done and timeout_err are one-cycle completion pulses.
module rw_flow_ctrl_burst #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned BL_W       = 3,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned TX_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_cmd,
  input  logic              rw,
  input  logic              active,
  input  logic              mode,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [BL_W-1:0]   burst_len,
  input  logic              tx_done,
  output logic              ac_mem,
  output logic              rw_mem,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              p_load,
  output logic              tx_dat,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);
  localparam int unsigned TMAX = TX_TIMEOUT > MEM_LAT ? TX_TIMEOUT : MEM_LAT;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  typedef enum logic [2:0] {IDLE, WRITE, RD_ACC, RD_WAIT, LOAD, TX, C_LOAD, C_TX} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BL_W-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              mode_q, mode_d, done_d, err_d, abort, tout;
  logic [4:0]        out_q, out_d;
  assign {ac_mem, rw_mem, p_load, tx_dat, busy} = out_q;
  assign mem_addr = addr_q;
  // one shared timer: latency wait in RD_WAIT, timeout in TX/C_TX; a zero TX_TIMEOUT never matches
  assign tout  = 32'(tmr_q) + 32'd1 == 32'(TX_TIMEOUT);
  assign abort = state_q != IDLE && state_q != WRITE && (!active || mode != mode_q);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    tmr_d   = tmr_q + TW'(1);
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (abort) state_d = IDLE;
    else case (state_q)
      IDLE: if (valid_cmd && active) begin
        addr_d  = addr_in;
        cnt_d   = burst_len == '0 ? BL_W'(1) : burst_len;
        mode_d  = mode;
        state_d = !mode ? C_LOAD : rw ? WRITE : RD_ACC;
      end
      WRITE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      RD_ACC: begin
        state_d = MEM_LAT > 1 ? RD_WAIT : LOAD;
        tmr_d   = '0;
      end
      RD_WAIT: if (32'(tmr_q) + 32'd1 == MEM_LAT - 1) state_d = LOAD;
      LOAD, C_LOAD: begin
        state_d = state_q == LOAD ? TX : C_TX;
        tmr_d   = '0;
      end
      TX, C_TX: if (tx_done) begin
        cnt_d = cnt_q - BL_W'(1);
        if (state_q == TX && cnt_q > BL_W'(1)) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = RD_ACC;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end else if (tout) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    out_d = state_d == WRITE  ? 5'b11001 :
            state_d == RD_ACC ? 5'b10001 :
            state_d == RD_WAIT ? 5'b00001 :
            (state_d == LOAD || state_d == C_LOAD) ? 5'b00101 :
            (state_d == TX || state_d == C_TX) ? 5'b00011 : 5'b00000;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      mode_q      <= 1'b0;
      out_q       <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      mode_q      <= mode_d;
      out_q       <= out_d;
      done        <= done_d;
      timeout_err <= err_d;
    end
  end
endmodule

// File: tb/tb_rw_flow_ctrl_burst.sv
// tb_rw_flow_ctrl_burst: directed self-checking bench for rw_flow_ctrl_burst (MEM_LAT=3, TX_TIMEOUT=10)
module tb_rw_flow_ctrl_burst;
  logic       clk = 1'b0, reset = 1'b0;
  logic       valid_cmd = 1'b0, rw = 1'b0, active = 1'b1, mode = 1'b0, tx_done = 1'b0;
  logic [7:0] addr_in = '0;
  logic [2:0] burst_len = '0;
  logic       ac_mem, rw_mem, p_load, tx_dat, busy, done, timeout_err;
  logic [7:0] mem_addr;
  logic [6:0] outs;
  int         n_chk = 0, n_err = 0;
  rw_flow_ctrl_burst #(.ADDR_W(8), .BL_W(3), .MEM_LAT(3), .TX_TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .valid_cmd(valid_cmd), .rw(rw), .active(active), .mode(mode),
    .addr_in(addr_in), .burst_len(burst_len), .tx_done(tx_done), .ac_mem(ac_mem), .rw_mem(rw_mem),
    .mem_addr(mem_addr), .p_load(p_load), .tx_dat(tx_dat), .busy(busy), .done(done),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  assign outs = {ac_mem, rw_mem, p_load, tx_dat, busy, done, timeout_err};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // one read word: RD_ACC, two RD_WAIT, LOAD, five TX cycles, tx_done raised in the fifth
  task automatic rd_word(input logic [7:0] a);
    tick;
    valid_cmd = 1'b0;
    tx_done   = 1'b0;
    chk("rd_acc", outs, 7'b1000100);
    chk("rd_addr", mem_addr, a);
    repeat (2) begin
      tick;
      chk("rd_wait", outs, 7'b0000100);
    end
    tick;
    chk("rd_load", outs, 7'b0010100);
    repeat (5) begin
      tick;
      chk("rd_tx", outs, 7'b0001100);
    end
    tx_done = 1'b1;
  endtask
  initial begin
    #3;
    chk("reset_outs", outs, 7'b0);
    chk("reset_addr", mem_addr, 8'h00);
    tick;
    reset = 1'b1;
    tick;
    chk("idle", outs, 7'b0);
    // write
    {mode, rw, addr_in, valid_cmd} = {1'b1, 1'b1, 8'h12, 1'b1};
    tick;
    valid_cmd = 1'b0;
    chk("wr_state", outs, 7'b1100100);
    chk("wr_addr", mem_addr, 8'h12);
    tick;
    chk("wr_done", outs, 7'b0000010);
    tick;
    chk("wr_after", outs, 7'b0);
    // burst of 3 from 0xFE with address wrap
    {rw, addr_in, burst_len, valid_cmd} = {1'b0, 8'hFE, 3'd3, 1'b1};
    rd_word(8'hFE);
    rd_word(8'hFF);
    rd_word(8'h00);
    tick;
    tx_done = 1'b0;
    chk("burst_done", outs, 7'b0000010);
    tick;
    chk("burst_after", outs, 7'b0);
    // calc-result transmit
    {mode, valid_cmd} = {1'b0, 1'b1};
    tick;
    valid_cmd = 1'b0;
    chk("c_load", outs, 7'b0010100);
    repeat (3) begin
      tick;
      chk("c_tx", outs, 7'b0001100);
    end
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    chk("c_done", outs, 7'b0000010);
    // timeout: ten C_TX cycles then error pulse
    valid_cmd = 1'b1;
    tick;
    valid_cmd = 1'b0;
    chk("to_load", outs, 7'b0010100);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("to_tx", outs, 7'b0001100);
    end
    tick;
    chk("to_err", outs, 7'b0000001);
    tick;
    chk("to_after", outs, 7'b0);
    // tx_done on the tenth cycle wins over timeout
    valid_cmd = 1'b1;
    tick;
    valid_cmd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("tod_tx", outs, 7'b0001100);
    end
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    chk("tod_done", outs, 7'b0000010);
    // abort by active=0 during RD_WAIT
    {mode, rw, addr_in, burst_len, valid_cmd} = {1'b1, 1'b0, 8'h30, 3'd2, 1'b1};
    tick;
    valid_cmd = 1'b0;
    chk("ab_acc", outs, 7'b1000100);
    tick;
    chk("ab_wait", outs, 7'b0000100);
    active = 1'b0;
    tick;
    chk("ab_idle", outs, 7'b0);
    tick;
    chk("ab_quiet", outs, 7'b0);
    active = 1'b1;
    // valid_cmd while busy ignored, then mode toggle in C_TX aborts
    {mode, valid_cmd} = {1'b0, 1'b1};
    tick;
    rw = 1'b1;
    tick;
    chk("busy_cmd_tx", outs, 7'b0001100);
    tick;
    chk("busy_cmd_hold", outs, 7'b0001100);
    {valid_cmd, mode} = {1'b0, 1'b1};
    tick;
    chk("mode_abort", outs, 7'b0);
    tick;
    chk("mode_quiet", outs, 7'b0);
    // asynchronous reset mid-burst, then burst_len=0 reads one word
    {rw, addr_in, burst_len, valid_cmd} = {1'b0, 8'h55, 3'd3, 1'b1};
    tick;
    valid_cmd = 1'b0;
    repeat (3) tick;
    chk("pre_rst_load", outs, 7'b0010100);
    #2 reset = 1'b0;
    #1;
    chk("arst_outs", outs, 7'b0);
    chk("arst_addr", mem_addr, 8'h00);
    reset = 1'b1;
    {addr_in, burst_len, valid_cmd} = {8'h40, 3'd0, 1'b1};
    rd_word(8'h40);
    tick;
    tx_done = 1'b0;
    chk("bl0_done", outs, 7'b0000010);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
